// File: rtl/fp_special_stage.sv
// Registered special-operand resolution stage for single-precision add/sub/mul/div.
// Results fixed by the operand classes leave with out_special=1. All other
// operand pairs pass through to the arithmetic core with out_special=0.
// Handshake (both sides): a beat moves when valid & ready are high at a rising
// edge. valid must not depend on ready. The held output stays stable while
// out_valid & !out_ready.
module fp_special_stage #(
  parameter logic [31:0] QNAN_CANON = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        in1_is_norm,
  input  logic        in1_is_subnorm,
  input  logic        in1_is_zero,
  input  logic        in1_is_inf,
  input  logic        in1_is_snan,
  input  logic        in1_is_qnan,
  input  logic        in2_is_norm,
  input  logic        in2_is_subnorm,
  input  logic        in2_is_zero,
  input  logic        in2_is_inf,
  input  logic        in2_is_snan,
  input  logic        in2_is_qnan,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_special,
  output logic [31:0] out_result,
  output logic [1:0]  out_op,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic        out_invalid,
  output logic        out_divzero,
  input  logic        flag_clr,
  output logic        sticky_invalid,
  output logic        sticky_divzero
);

  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  logic        accept;
  logic        s1, s2, sx;
  logic        fin1, fin2;
  logic        res_special, res_invalid, res_divzero;
  logic [31:0] res_value;

  logic        out_valid_q,   out_valid_d;
  logic        out_special_q, out_special_d;
  logic [31:0] out_result_q,  out_result_d;
  logic [1:0]  out_op_q,      out_op_d;
  logic [31:0] out_a_q,       out_a_d;
  logic [31:0] out_b_q,       out_b_d;
  logic        out_invalid_q, out_invalid_d;
  logic        out_divzero_q, out_divzero_d;
  logic        sticky_inv_q,  sticky_inv_d;
  logic        sticky_dz_q,   sticky_dz_d;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Class-driven result resolution, first matching rule wins.
  always_comb begin
    s1          = in1[31];
    s2          = in2[31] ^ (op == OP_SUB);
    sx          = in1[31] ^ in2[31];
    fin1        = in1_is_norm || in1_is_subnorm;
    fin2        = in2_is_norm || in2_is_subnorm;
    res_special = 1'b1;
    res_value   = 32'd0;
    res_invalid = 1'b0;
    res_divzero = 1'b0;
    if (in1_is_snan || in2_is_snan) begin
      res_value   = QNAN_CANON;
      res_invalid = 1'b1;
    end else if (in1_is_qnan || in2_is_qnan) begin
      res_value = QNAN_CANON;
    end else if (op[1] == 1'b0) begin
      // add / sub with the effective sign of in2
      if (in1_is_inf && in2_is_inf && (s1 != s2)) begin
        res_value   = QNAN_CANON;
        res_invalid = 1'b1;
      end else if (in1_is_inf) begin
        res_value = {s1, 8'hFF, 23'd0};
      end else if (in2_is_inf) begin
        res_value = {s2, 8'hFF, 23'd0};
      end else if (in1_is_zero && in2_is_zero) begin
        res_value = {s1 & s2, 31'd0};
      end else if (in1_is_zero && fin2) begin
        res_value = {s2, in2[30:0]};
      end else if (in2_is_zero && fin1) begin
        res_value = in1;
      end else begin
        res_special = 1'b0;
      end
    end else if (op == OP_MUL) begin
      if ((in1_is_inf && in2_is_zero) || (in1_is_zero && in2_is_inf)) begin
        res_value   = QNAN_CANON;
        res_invalid = 1'b1;
      end else if (in1_is_inf || in2_is_inf) begin
        res_value = {sx, 8'hFF, 23'd0};
      end else if (in1_is_zero || in2_is_zero) begin
        res_value = {sx, 31'd0};
      end else begin
        res_special = 1'b0;
      end
    end else begin
      // div
      if ((in1_is_zero && in2_is_zero) || (in1_is_inf && in2_is_inf)) begin
        res_value   = QNAN_CANON;
        res_invalid = 1'b1;
      end else if (in1_is_inf) begin
        res_value = {sx, 8'hFF, 23'd0};
      end else if (in2_is_inf || in1_is_zero) begin
        res_value = {sx, 31'd0};
      end else if (in2_is_zero && fin1) begin
        res_value   = {sx, 8'hFF, 23'd0};
        res_divzero = 1'b1;
      end else begin
        res_special = 1'b0;
      end
    end
  end

  // Next-state for the output register and sticky flags.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_special_d = out_special_q;
    out_result_d  = out_result_q;
    out_op_d      = out_op_q;
    out_a_d       = out_a_q;
    out_b_d       = out_b_q;
    out_invalid_d = out_invalid_q;
    out_divzero_d = out_divzero_q;
    sticky_inv_d  = sticky_inv_q;
    sticky_dz_d   = sticky_dz_q;
    if (accept) begin
      out_valid_d   = 1'b1;
      out_special_d = res_special;
      out_result_d  = res_value;
      out_op_d      = op;
      out_a_d       = in1;
      out_b_d       = in2;
      out_invalid_d = res_invalid;
      out_divzero_d = res_divzero;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // a flag raised by this cycle's accept beats a simultaneous clear
    if (accept && res_invalid) sticky_inv_d = 1'b1;
    else if (flag_clr)         sticky_inv_d = 1'b0;
    if (accept && res_divzero) sticky_dz_d = 1'b1;
    else if (flag_clr)         sticky_dz_d = 1'b0;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_special_q <= 1'b0;
      out_result_q  <= 32'd0;
      out_op_q      <= 2'd0;
      out_a_q       <= 32'd0;
      out_b_q       <= 32'd0;
      out_invalid_q <= 1'b0;
      out_divzero_q <= 1'b0;
      sticky_inv_q  <= 1'b0;
      sticky_dz_q   <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_special_q <= out_special_d;
      out_result_q  <= out_result_d;
      out_op_q      <= out_op_d;
      out_a_q       <= out_a_d;
      out_b_q       <= out_b_d;
      out_invalid_q <= out_invalid_d;
      out_divzero_q <= out_divzero_d;
      sticky_inv_q  <= sticky_inv_d;
      sticky_dz_q   <= sticky_dz_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_special    = out_special_q;
  assign out_result     = out_result_q;
  assign out_op         = out_op_q;
  assign out_a          = out_a_q;
  assign out_b          = out_b_q;
  assign out_invalid    = out_invalid_q;
  assign out_divzero    = out_divzero_q;
  assign sticky_invalid = sticky_inv_q;
  assign sticky_divzero = sticky_dz_q;

endmodule

// File: tb/tb_fp_special_stage.sv
// Bench for fp_special_stage: directed cases with literal expectations plus a
// randomized run checked every cycle against a class-level reference model.
module tb_fp_special_stage;

  localparam int W = 101; // {special, result, op, a, b, invalid, divzero}
  localparam logic [31:0] QN = 32'h7FC00000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_ready, out_ready = 1'b1, flag_clr = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] in1 = 32'd0, in2 = 32'd0;
  logic [5:0]  c1 = 6'b001000, c2 = 6'b001000; // {norm,subnorm,zero,inf,snan,qnan}
  logic        out_valid, out_special, out_invalid, out_divzero;
  logic [31:0] out_result, out_a, out_b;
  logic [1:0]  out_op;
  logic        sticky_invalid, sticky_divzero;

  fp_special_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .in1(in1), .in2(in2),
    .in1_is_norm(c1[5]), .in1_is_subnorm(c1[4]), .in1_is_zero(c1[3]),
    .in1_is_inf(c1[2]), .in1_is_snan(c1[1]), .in1_is_qnan(c1[0]),
    .in2_is_norm(c2[5]), .in2_is_subnorm(c2[4]), .in2_is_zero(c2[3]),
    .in2_is_inf(c2[2]), .in2_is_snan(c2[1]), .in2_is_qnan(c2[0]),
    .out_valid(out_valid), .out_ready(out_ready), .out_special(out_special),
    .out_result(out_result), .out_op(out_op), .out_a(out_a), .out_b(out_b),
    .out_invalid(out_invalid), .out_divzero(out_divzero), .flag_clr(flag_clr),
    .sticky_invalid(sticky_invalid), .sticky_divzero(sticky_divzero)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // IEEE-754 classification straight from the bit fields
  function automatic logic [5:0] classify(input logic [31:0] v);
    if (v[30:23] == 8'hFF) begin
      if (v[22:0] == 23'd0) return 6'b000100;
      return v[22] ? 6'b000001 : 6'b000010;
    end
    if (v[30:23] == 8'h00) return (v[22:0] == 23'd0) ? 6'b001000 : 6'b010000;
    return 6'b100000;
  endfunction

  // reference model: expected output word for one accepted operation
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [5:0] ca, cb;
    logic za, zb, ia, ib, sa, sb, sx, sp, inv, dz;
    logic [31:0] r;
    ca = classify(a); cb = classify(b);
    za = ca[3]; zb = cb[3]; ia = ca[2]; ib = cb[2];
    sa = a[31]; sb = b[31] ^ (o == 2'd1); sx = a[31] ^ b[31];
    sp = 1'b1; r = 32'd0; inv = 1'b0; dz = 1'b0;
    if (ca[1] || cb[1]) begin r = QN; inv = 1'b1; end
    else if (ca[0] || cb[0]) r = QN;
    else if (o == 2'd0 || o == 2'd1) begin
      if (ia && ib && sa != sb) begin r = QN; inv = 1'b1; end
      else if (ia) r = {sa, 8'hFF, 23'd0};
      else if (ib) r = {sb, 8'hFF, 23'd0};
      else if (za && zb) r = {sa & sb, 31'd0};
      else if (za) r = {sb, b[30:0]};
      else if (zb) r = a;
      else sp = 1'b0;
    end else if (o == 2'd2) begin
      if ((ia && zb) || (za && ib)) begin r = QN; inv = 1'b1; end
      else if (ia || ib) r = {sx, 8'hFF, 23'd0};
      else if (za || zb) r = {sx, 31'd0};
      else sp = 1'b0;
    end else begin
      if ((za && zb) || (ia && ib)) begin r = QN; inv = 1'b1; end
      else if (ia) r = {sx, 8'hFF, 23'd0};
      else if (ib || za) r = {sx, 31'd0};
      else if (zb) begin r = {sx, 8'hFF, 23'd0}; dz = 1'b1; end
      else sp = 1'b0;
    end
    return {sp, r, o, a, b, inv, dz};
  endfunction

  // scoreboard state: queue of accepted-but-not-transferred results
  logic [W-1:0] exp_q[$];
  logic m_valid = 1'b0, m_sinv = 1'b0, m_sdz = 1'b0;

  // model update on each clock edge from the sampled inputs
  initial begin
    logic acc;
    logic [W-1:0] e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete(); m_valid = 1'b0; m_sinv = 1'b0; m_sdz = 1'b0;
      end else begin
        acc = in_valid && (!m_valid || out_ready);
        if (m_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        e = model(op, in1, in2);
        if (acc) exp_q.push_back(e);
        m_valid = acc ? 1'b1 : (out_ready ? 1'b0 : m_valid);
        if (acc && e[1]) m_sinv = 1'b1; else if (flag_clr) m_sinv = 1'b0;
        if (acc && e[0]) m_sdz = 1'b1;  else if (flag_clr) m_sdz = 1'b0;
      end
    end
  end

  // compare process on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, !m_valid || out_ready});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("sticky_invalid", {31'd0, sticky_invalid}, {31'd0, m_sinv});
        chk("sticky_divzero", {31'd0, sticky_divzero}, {31'd0, m_sdz});
        if (m_valid) begin
          if (exp_q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
          else begin
            chk("sb_special", {31'd0, out_special}, {31'd0, exp_q[0][100]});
            chk("sb_result", out_result, exp_q[0][99:68]);
            chk("sb_op", {30'd0, out_op}, {30'd0, exp_q[0][67:66]});
            chk("sb_a", out_a, exp_q[0][65:34]);
            chk("sb_b", out_b, exp_q[0][33:2]);
            chk("sb_flags", {30'd0, out_invalid, out_divzero}, {30'd0, exp_q[0][1:0]});
          end
        end
      end
    end
  end

  // driver tasks
  task automatic set_in(input logic v, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    in_valid = v; op = o; in1 = a; in2 = b; c1 = classify(a); c2 = classify(b);
  endtask

  // one transaction with out_ready high; returns on the negedge showing its result
  task automatic xact(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2 set_in(1'b1, o, a, b);
    @(posedge clk); #2 in_valid = 1'b0; flag_clr = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0: v = {s, 31'd0};
      1: v = {s, 8'hFF, 23'd0};
      2: v = {s, 8'hFF, 1'b0, 22'($urandom_range(1, 4194303))};
      3: v = {s, 8'hFF, 1'b1, 22'($urandom())};
      4: v = {s, 8'h00, 23'($urandom_range(1, 8388607))};
      default: v = {s, 8'($urandom_range(1, 254)), 23'($urandom())};
    endcase
    return v;
  endfunction

  logic [31:0] held;

  initial begin
    logic [W-1:0] m;
    // model pins
    m = model(2'd2, 32'h7F800000, 32'h00000000);
    chk("pin_mul_inf_zero", m[99:68], QN);
    chk("pin_mul_inf_zero_inv", {31'd0, m[1]}, 32'd1);
    m = model(2'd3, 32'hBF800000, 32'h00000000);
    chk("pin_div_neg_by_zero", m[99:68], 32'hFF800000);
    m = model(2'd1, 32'h00000000, 32'h00000000);
    chk("pin_sub_zero_zero", m[99:68], 32'h00000000);

    // reset values
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_sticky", {30'd0, sticky_invalid, sticky_divzero}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    xact(2'd2, 32'h7F800000, 32'h00000000);
    chk("mul_inf0_valid", {31'd0, out_valid}, 32'd1);
    chk("mul_inf0_special", {31'd0, out_special}, 32'd1);
    chk("mul_inf0_result", out_result, 32'h7FC00000);
    chk("mul_inf0_invalid", {31'd0, out_invalid}, 32'd1);
    chk("mul_inf0_sticky", {31'd0, sticky_invalid}, 32'd1);
    xact(2'd1, 32'h7F800000, 32'h7F800000);
    chk("sub_infinf_result", out_result, 32'h7FC00000);
    chk("sub_infinf_invalid", {31'd0, out_invalid}, 32'd1);
    xact(2'd0, 32'h7F800000, 32'h7F800000);
    chk("add_infinf_result", out_result, 32'h7F800000);
    chk("add_infinf_invalid", {31'd0, out_invalid}, 32'd0);
    xact(2'd3, 32'h3F800000, 32'h00000000);
    chk("div_by0_result", out_result, 32'h7F800000);
    chk("div_by0_divzero", {31'd0, out_divzero}, 32'd1);
    xact(2'd3, 32'h80000000, 32'h00000000);
    chk("div_00_result", out_result, 32'h7FC00000);
    chk("div_00_flags", {30'd0, out_invalid, out_divzero}, 32'd2);
    xact(2'd0, 32'h3F800000, 32'h40000000);
    chk("add_norm_special", {31'd0, out_special}, 32'd0);
    chk("add_norm_result", out_result, 32'd0);
    chk("add_norm_a", out_a, 32'h3F800000);
    chk("add_norm_b", out_b, 32'h40000000);
    xact(2'd0, 32'h00000001, 32'h80000000);
    chk("add_sub_negz_special", {31'd0, out_special}, 32'd1);
    chk("add_sub_negz_result", out_result, 32'h00000001);

    // stall: out_ready low for 3 cycles with a second input waiting
    @(posedge clk); #2 out_ready = 1'b0; set_in(1'b1, 2'd2, 32'hC0000000, 32'h7F800000);
    @(posedge clk); #2 set_in(1'b1, 2'd3, 32'h40400000, 32'h00000000);
    @(negedge clk); held = out_result;
    chk("stall_result0", out_result, 32'hFF800000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_hold", out_result, held);
    end
    @(posedge clk); #2 out_ready = 1'b1;
    @(posedge clk); #2 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_result", out_result, 32'h7F800000);
    chk("b2b_divzero", {31'd0, out_divzero}, 32'd1);

    // sticky set-over-clear
    xact(2'd0, 32'h7F800001, 32'h3F800000);
    chk("sticky_snan", {31'd0, sticky_invalid}, 32'd1);
    @(posedge clk); #2 flag_clr = 1'b1; set_in(1'b1, 2'd0, 32'h7F800001, 32'h3F800000);
    @(posedge clk); #2 flag_clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("sticky_set_wins", {31'd0, sticky_invalid}, 32'd1);
    @(posedge clk); #2 flag_clr = 1'b1;
    @(posedge clk); #2 flag_clr = 1'b0;
    @(negedge clk);
    chk("sticky_cleared", {30'd0, sticky_invalid, sticky_divzero}, 32'd0);

    // reset during a stall
    @(posedge clk); #2 out_ready = 1'b0; set_in(1'b1, 2'd2, 32'h7F800000, 32'h00000000);
    @(posedge clk); #2 in_valid = 1'b0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_result", out_result, 32'd0);
    chk("midrst_misc", {out_special, out_op, out_invalid, out_divzero, sticky_invalid}, 32'd0);
    chk("midrst_ab", out_a | out_b, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1; out_ready = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      set_in($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rand_operand(), rand_operand());
      out_ready = ($urandom_range(0, 3) != 0);
      flag_clr  = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk); #2 in_valid = 1'b0; out_ready = 1'b1; flag_clr = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
